fb_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_fifo.sv | 69 ++++++
 rtl/fb_writer.sv | 115 +++++++++++
 tb/tb_fb_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write stage.
// Holds the write-FSM state encoding and the RGB565 pixel field layout.
// Imported by fb_fifo and fb_writer.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fb_state_t;

    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    typedef struct packed {
        logic [RGB_R_W-1:0] r;
        logic [RGB_G_W-1:0] g;
        logic [RGB_B_W-1:0] b;
    } rgb565_t;

endpackage

// File: rtl/fb_fifo.sv
// Single-clock first-word-fall-through FIFO for framebuffer pixels.
// Latency: a pushed word is visible on head_data the cycle after the push (if the FIFO was empty).
// Backpressure: pushes while full and pops while empty are ignored; clr empties it synchronously.
// Ports: clkSYS/n_reset clock and async active-low reset; clr synchronous flush;
//        push/push_data write side; pop/head_data read side (head valid whenever level != 0);
//        level current occupancy.
module fb_fifo #(
    parameter int DN    = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clkSYS,
    input  logic                     n_reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DN-1:0]            push_data,
    input  logic                     pop,
    output logic [DN-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   level
);
    import fb_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DN-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A flush wins over any concurrent push or pop.
    assign do_push = push & (level != FULL_LVL) & ~clr;
    assign do_pop  = pop & (level != '0) & ~clr;

    // Head word comes straight from the storage array, so it follows rd_ptr
    // on the cycle after each pop.
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clkSYS) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write stage: packs PPU pixels into BURST-word write requests to the SDRAM arbiter.
// Latency: request rises 1 cycle after the BURST-th word lands; word 0 is on wr_data the cycle after req_ack.
// Backpressure: pix_ready drops when the FIFO is full or an SOF pixel waits for the residual flush.
// Ports: clkSYS/n_reset clock and async active-low reset;
//        pix_data/pix_valid/pix_sof/pix_ready pixel input with frame-start marker;
//        req_addr/request/req_ack write-slot handshake; wr_next/wr_data burst word stream;
//        level FIFO occupancy and drop sticky discarded-partial-burst flag (debug).
module fb_writer
    import fb_pkg::*;
#(
    parameter int          AN    = 24,
    parameter int          DN    = 16,
    parameter int          BURST = 8,
    parameter logic [AN-1:0] BASE = '0,
    parameter int          DEPTH = 16
) (
    input  logic                     clkSYS,
    input  logic                     n_reset,
    input  logic [DN-1:0]            pix_data,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    output logic [AN-1:0]            req_addr,
    output logic                     request,
    input  logic                     req_ack,
    input  logic                     wr_next,
    output logic [DN-1:0]            wr_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(BURST);
    localparam logic [LW-1:0] BURST_LVL = LW'(BURST);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT  = CW'(BURST - 1);

    fb_state_t     state;
    logic [CW-1:0] pop_cnt;
    logic          sof_req;
    logic          sof_block;
    logic          flush;
    logic          fifo_clr;
    logic          push;
    logic          pop;
    logic          last_pop;

    assign sof_req   = pix_valid & pix_sof;
    // A new frame may only enter an idle, empty writer; otherwise it waits for
    // the in-flight burst to finish and any residual words to be flushed.
    assign sof_block = sof_req & ((state != ST_IDLE) | (level != '0));
    assign pix_ready = (level < DEPTH_LVL) & ~sof_block;
    assign push      = pix_valid & pix_ready;
    assign pop       = wr_next & (state == ST_DATA);
    assign last_pop  = pop & (pop_cnt == LAST_CNT);
    assign request   = (state == ST_REQ);

    // Full bursts already buffered are written out first; only a partial
    // tail is thrown away when a new frame starts.
    assign flush    = (state == ST_IDLE) & sof_req & (level < BURST_LVL);
    assign fifo_clr = flush & (level != '0);

    fb_fifo #(
        .DN    (DN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clkSYS    (clkSYS),
        .n_reset   (n_reset),
        .clr       (fifo_clr),
        .push      (push),
        .push_data (pix_data),
        .pop       (pop),
        .head_data (wr_data),
        .level     (level)
    );

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state    <= ST_IDLE;
            req_addr <= BASE;
            pop_cnt  <= '0;
            drop     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        req_addr <= BASE;
                        if (fifo_clr) begin
                            drop <= 1'b1;
                        end
                    end else if (level >= BURST_LVL) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_ack) begin
                        state   <= ST_DATA;
                        pop_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (pop) begin
                        pop_cnt <= pop_cnt + CW'(1);
                        if (last_pop) begin
                            // Wraps silently at the top of the address space.
                            req_addr <= req_addr + AN'(BURST);
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        req_ack;
    logic        wr_next;

    logic        pix_ready, request, drop;
    logic [23:0] req_addr;
    logic [15:0] wr_data;
    logic [4:0]  level;

    logic        w_pix_ready, w_request, w_drop;
    logic [23:0] w_req_addr;
    logic [15:0] w_wr_data;
    logic [4:0]  w_level;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fb_writer #(.AN(24), .DN(16), .BURST(8), .BASE(24'h000000), .DEPTH(16)) dut (
        .clkSYS(clk), .n_reset(n_reset), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .req_addr(req_addr), .request(request),
        .req_ack(req_ack), .wr_next(wr_next), .wr_data(wr_data), .level(level), .drop(drop)
    );

    // Same stimulus, base placed 8 words below the top of the address space.
    fb_writer #(.AN(24), .DN(16), .BURST(8), .BASE(24'hFFFFF8), .DEPTH(16)) dut_w (
        .clkSYS(clk), .n_reset(n_reset), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(w_pix_ready), .req_addr(w_req_addr), .request(w_request),
        .req_ack(req_ack), .wr_next(wr_next), .wr_data(w_wr_data), .level(w_level), .drop(w_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel is taken.
    task automatic push_pix(input logic [15:0] d, input logic s);
        int n = 0;
        pix_data  = d;
        pix_valid = 1'b1;
        pix_sof   = s;
        @(negedge clk);
        while (pix_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        exp_q.push_back(d);
    endtask

    // One-cycle pop; the head word is compared against the scoreboard.
    task automatic pop_word(input string tag);
        logic [15:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        wr_next = 1'b1;
        @(negedge clk);
        chk(tag, 32'(wr_data), 32'(e));
        @(posedge clk); #1;
        wr_next = 1'b0;
    endtask

    // Waits (bounded) for request, then acks two cycles after it is seen.
    task automatic grant();
        int n = 0;
        while (request !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("request_seen", 32'(request), 32'd1);
        @(posedge clk); #1;
        req_ack = 1'b1;
        @(posedge clk); #1;
        req_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        n_reset = 1'b0; pix_data = '0; pix_valid = 1'b0; pix_sof = 1'b0;
        req_ack = 1'b0; wr_next = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_request", 32'(request), 32'd0);
        chk("rst_addr", 32'(req_addr), 32'h000000);
        chk("rst_addr_w", 32'(w_req_addr), 32'hFFFFF8);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;

        // Streaming burst 0x0001..0x0008
        for (int i = 1; i <= 8; i++) push_pix(16'(i), 1'b0);
        @(negedge clk);
        chk("s1_level8", 32'(level), 32'd8);
        chk("s1_req_lat0", 32'(request), 32'd0);
        @(negedge clk);
        chk("s1_req_lat1", 32'(request), 32'd1);
        chk("s1_addr", 32'(req_addr), 32'h000000);
        @(posedge clk); #1;
        grant();
        @(negedge clk);
        chk("s1_req_fall", 32'(request), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) pop_word("s1_data");
        @(negedge clk);
        chk("s1_next_addr", 32'(req_addr), 32'h000008);
        chk("s1_wrap_addr", 32'(w_req_addr), 32'h000000);
        chk("s1_level0", 32'(level), 32'd0);
        @(posedge clk); #1;

        // Fill to 16 with no ack; 17th pixel held
        for (int i = 1; i <= 16; i++) push_pix(16'h0100 + 16'(i), 1'b0);
        pix_data = 16'h0111; pix_valid = 1'b1; pix_sof = 1'b0;
        @(negedge clk);
        chk("f_level16", 32'(level), 32'd16);
        chk("f_ready0", 32'(pix_ready), 32'd0);
        @(negedge clk);
        chk("f_held", 32'(pix_ready), 32'd0);
        grant();
        chk("f_addr", 32'(req_addr), 32'h000008);
        begin : full_pop
            logic [15:0] e;
            e = exp_q.pop_front();
            wr_next = 1'b1;
            @(negedge clk);
            chk("f_ready_fullpop", 32'(pix_ready), 32'd0);
            chk("f_data0", 32'(wr_data), 32'(e));
            @(posedge clk); #1;
            wr_next = 1'b0;
        end
        @(negedge clk);
        chk("f_level15", 32'(level), 32'd15);
        chk("f_ready1", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        exp_q.push_back(16'h0111);
        @(negedge clk);
        chk("f_level16b", 32'(level), 32'd16);
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) pop_word("f_data");

        // Gapped wr_next: one pop every 3rd cycle
        grant();
        chk("g_addr", 32'(req_addr), 32'h000010);
        for (int i = 0; i < 8; i++) begin
            pop_word("g_data");
            @(negedge clk);
            chk("g_state", 32'(dut.state), (i < 7) ? 32'(ST_DATA) : 32'(ST_IDLE));
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        chk("g_level1", 32'(level), 32'd1);

        // SOF with 5 residual words
        for (int i = 1; i <= 4; i++) push_pix(16'h0200 + 16'(i), 1'b0);
        @(negedge clk);
        chk("sof_level5", 32'(level), 32'd5);
        chk("sof_addr_pre", 32'(req_addr), 32'h000018);
        @(posedge clk); #1;
        exp_q.delete();
        pix_data = 16'hABCD; pix_valid = 1'b1; pix_sof = 1'b1;
        @(negedge clk);
        chk("sof_blocked", 32'(pix_ready), 32'd0);
        @(negedge clk);
        chk("sof_level0", 32'(level), 32'd0);
        chk("sof_drop", 32'(drop), 32'd1);
        chk("sof_addr", 32'(req_addr), 32'h000000);
        chk("sof_ready", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        exp_q.push_back(16'hABCD);
        for (int i = 1; i <= 7; i++) push_pix(16'h0300 + 16'(i), 1'b0);
        grant();
        chk("sof_burst_addr", 32'(req_addr), 32'h000000);
        for (int i = 0; i < 8; i++) pop_word("sof_data");
        @(negedge clk);
        chk("sof_next_addr", 32'(req_addr), 32'h000008);
        @(posedge clk); #1;

        // Reset mid-DATA after 3 pops
        for (int i = 1; i <= 8; i++) push_pix(16'h0400 + 16'(i), 1'b0);
        grant();
        for (int i = 0; i < 3; i++) pop_word("r_data");
        n_reset = 1'b0;
        @(negedge clk);
        chk("r_request", 32'(request), 32'd0);
        chk("r_level", 32'(level), 32'd0);
        chk("r_addr", 32'(req_addr), 32'h000000);
        chk("r_drop", 32'(drop), 32'd0);
        chk("r_state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge clk); #1;
        n_reset = 1'b1;
        exp_q.delete();
        wr_next = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_next = 1'b0;
        @(negedge clk);
        chk("r_spurious_level", 32'(level), 32'd0);
        chk("r_spurious_req", 32'(request), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
